// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard, decode hazard detection,
// optional write-through bypass (REGFILE_BYPASS_EN) and a saturating stall counter.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 16,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   input  logic             rs1_used,
   input  logic             rs2_used,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   input  logic             issue_valid,
   input  logic             issue_rd_en,
   input  logic [AW-1:0]    issue_rd,
   output logic             hazard,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic [CNT_W-1:0] hazard_cnt
);

   logic [XLEN-1:0]  rf_word [NREG];
   logic [NREG-1:0]  wb_hit;
   logic [NREG-1:0]  ebusy;
   logic [NREG-1:0]  busy_reg;
   logic [NREG-1:0]  busy_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             rs1_fwd;
   logic             rs2_fwd;
   logic             hazard_raw;
   logic             fire;

   // x0 has no storage and never matches a writeback, so it reads 0 and is never busy
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign rf_word[gi] = '0;
            assign wb_hit[gi]  = 1'b0;
         end else begin : g_word
            logic [XLEN-1:0] q_reg;
            assign wb_hit[gi]  = wb_en && (wb_addr == AW'(gi));
            assign rf_word[gi] = q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  q_reg <= '0;
               else if (wb_hit[gi])
                  q_reg <= wb_data;
            end
         end
      end
   endgenerate

`ifdef REGFILE_BYPASS_EN
   assign ebusy   = busy_reg & ~wb_hit;
   assign rs1_fwd = wb_hit[rs1_addr];
   assign rs2_fwd = wb_hit[rs2_addr];
`else
   assign ebusy   = busy_reg;
   assign rs1_fwd = 1'b0;
   assign rs2_fwd = 1'b0;
`endif

   assign rs1_data = !rst_n ? '0 : (rs1_fwd ? wb_data : rf_word[rs1_addr]);
   assign rs2_data = !rst_n ? '0 : (rs2_fwd ? wb_data : rf_word[rs2_addr]);

   assign hazard_raw = issue_valid && !flush &&
                       ((rs1_used    && ebusy[rs1_addr]) ||
                        (rs2_used    && ebusy[rs2_addr]) ||
                        (issue_rd_en && ebusy[issue_rd]));
   assign hazard     = rst_n && hazard_raw;

   assign fire = issue_valid && !flush && !hazard_raw && issue_rd_en && (issue_rd != '0);

   // Set is applied after the writeback clear so a new producer stays outstanding
   always_comb begin
      busy_next = busy_reg & ~wb_hit;
      if (fire)
         busy_next[issue_rd] = 1'b1;
      if (flush)
         busy_next = '0;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_reg <= '0;
      else
         busy_reg <= busy_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (hazard_raw && (cnt_reg != {CNT_W{1'b1}}))
         cnt_reg <= cnt_reg + CNT_W'(1);
   end

   assign hazard_cnt = cnt_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random traffic
// compared against an array-based behavioural model.
module tb_regfile_scoreboard;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int CNT_W = 4;
   localparam int AW    = 5;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [AW-1:0]    rs1_addr, rs2_addr, issue_rd, wb_addr;
   logic             rs1_used, rs2_used, issue_valid, issue_rd_en, wb_en, flush, hazard;
   logic [XLEN-1:0]  rs1_data, rs2_data, wb_data;
   logic [CNT_W-1:0] hazard_cnt;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_rf [NREG];
   bit              m_busy [NREG];
   int              m_cnt;

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
      .hazard(hazard), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .hazard_cnt(hazard_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] m_read(logic [AW-1:0] a);
      if (a == 0) return '0;
      if (BYP && wb_en && wb_addr == a) return wb_data;
      return m_rf[a];
   endfunction

   function automatic bit m_ebusy(logic [AW-1:0] r);
      return m_busy[r] && !(BYP && wb_en && wb_addr == r);
   endfunction

   function automatic bit m_hazard();
      return issue_valid && !flush &&
             ((rs1_used && m_ebusy(rs1_addr)) || (rs2_used && m_ebusy(rs2_addr)) ||
              (issue_rd_en && m_ebusy(issue_rd)));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) begin
         m_rf[i]   = '0;
         m_busy[i] = 1'b0;
      end
      m_cnt = 0;
   endtask

   task automatic check(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rs1_addr = '0; rs2_addr = '0; rs1_used = 0; rs2_used = 0;
      issue_valid = 0; issue_rd_en = 0; issue_rd = '0;
      wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask

   task automatic settle_check();
      #1;
      check("rs1_data", rs1_data, m_read(rs1_addr));
      check("rs2_data", rs2_data, m_read(rs2_addr));
      check("hazard", XLEN'(hazard), XLEN'(m_hazard()));
      check("hazard_cnt", XLEN'(hazard_cnt), XLEN'(m_cnt));
   endtask

   task automatic tick();
      bit hz, fire;
      hz   = m_hazard();
      fire = issue_valid && !flush && !hz && issue_rd_en && issue_rd != 0;
      @(posedge clk);
      if (hz && m_cnt < CMAX) m_cnt++;
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
      if (flush) begin
         for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
         if (wb_en && wb_addr != 0) m_busy[wb_addr] = 1'b0;
         if (fire) m_busy[issue_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic step();
      settle_check();
      tick();
   endtask

   task automatic read_all_zero();
      idle();
      for (int a = 0; a < NREG; a++) begin
         rs1_addr = AW'(a);
         rs2_addr = AW'(NREG - 1 - a);
         settle_check();
         check("rd_all_a", rs1_data, '0);
         check("rd_all_b", rs2_data, '0);
         tick();
      end
   endtask

   initial begin
      idle();
      m_reset();
      // reset state, with activity on the inputs that must be masked
      rs1_addr = 5; rs1_used = 1; issue_valid = 1; wb_en = 1; wb_addr = 5; wb_data = 32'hA5A5A5A5;
      #1;
      check("rst_rs1", rs1_data, '0);
      check("rst_hazard", XLEN'(hazard), '0);
      check("rst_cnt", XLEN'(hazard_cnt), '0);
      @(negedge clk);
      @(negedge clk);
      idle();
      rst_n = 1;
      read_all_zero();

      // x0 is hardwired
      wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF; rs1_addr = 0;
      step();
      idle(); rs1_addr = 0; settle_check();
      check("x0_read", rs1_data, '0);
      tick();
      issue_valid = 1; issue_rd_en = 1; issue_rd = 0; step();
      idle(); issue_valid = 1; rs1_used = 1; rs1_addr = 0; rs2_used = 1; rs2_addr = 0;
      settle_check();
      check("x0_nohaz", XLEN'(hazard), '0);
      tick();

      // RAW on x5 for three cycles, then resolved by writeback
      idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 5; step();
      idle(); issue_valid = 1; rs1_used = 1; rs1_addr = 5;
      for (int i = 0; i < 3; i++) begin
         settle_check();
         check("raw_haz", XLEN'(hazard), 1);
         tick();
      end
      settle_check();
      check("raw_cnt3", XLEN'(hazard_cnt), 3);
      wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
      settle_check();
      check("wb_same_haz", XLEN'(hazard), BYP ? 0 : 1);
      check("wb_same_data", rs1_data, BYP ? 32'h12345678 : 32'h0);
      tick();
      wb_en = 0; settle_check();
      check("wb_next_data", rs1_data, 32'h12345678);
      check("wb_next_haz", XLEN'(hazard), 0);
      tick();

      // same-cycle issue and writeback on one register
      idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 7; step();
      wb_en = 1; wb_addr = 7; wb_data = 32'h00000077; step();
      idle(); issue_valid = 1; rs1_used = 1; rs1_addr = 7; settle_check();
      check("waw7_stall", XLEN'(hazard), BYP ? 1 : 0);
      tick();
      idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 8;
      wb_en = 1; wb_addr = 8; wb_data = 32'h00000088; step();
      idle(); issue_valid = 1; rs1_used = 1; rs1_addr = 8; settle_check();
      check("set_wins8", XLEN'(hazard), 1);
      tick();

      // flush clears everything and drops the concurrent issue
      idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 3; step();
      issue_rd = 9; step();
      issue_rd = 4; flush = 1; step();
      idle(); issue_valid = 1; rs1_used = 1; rs2_used = 1; rs1_addr = 3; rs2_addr = 9;
      settle_check();
      check("flush_39", XLEN'(hazard), 0);
      tick();
      rs1_addr = 4; rs2_addr = 7; settle_check();
      check("flush_4", XLEN'(hazard), 0);
      tick();

      // random traffic on a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         rs1_addr    = AW'($urandom_range(0, 7));
         rs2_addr    = AW'($urandom_range(0, 7));
         rs1_used    = 1'($urandom_range(0, 1));
         rs2_used    = 1'($urandom_range(0, 1));
         issue_valid = ($urandom_range(0, 99) < 60);
         issue_rd_en = 1'($urandom_range(0, 1));
         issue_rd    = AW'($urandom_range(0, 7));
         wb_en       = ($urandom_range(0, 99) < 40);
         wb_addr     = AW'($urandom_range(0, 7));
         wb_data     = $urandom;
         flush       = ($urandom_range(0, 99) < 5);
         step();
      end

      // counter saturation, then asynchronous reset in the middle of a stall
      idle();
      rst_n = 0; m_reset(); #1; rst_n = 1;
      wb_en = 1; wb_addr = 5; wb_data = 32'hCAFEF00D; step();
      idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 5; step();
      idle(); issue_valid = 1; rs1_used = 1; rs1_addr = 5; rs2_addr = 5;
      for (int i = 0; i < 20; i++) step();
      settle_check();
      check("sat_cnt", XLEN'(hazard_cnt), XLEN'(CMAX));
      rst_n = 0; m_reset();
      #1;
      check("mid_rst_cnt", XLEN'(hazard_cnt), '0);
      check("mid_rst_haz", XLEN'(hazard), '0);
      check("mid_rst_rs1", rs1_data, '0);
      @(negedge clk);
      idle();
      rst_n = 1;
      read_all_zero();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
